// File: rtl/comparator_frame_minmax.sv
// Streaming frame min/max tracker: running extrema with first-occurrence
// indices and a saturating beat count, emitted as one result beat per frame.
module comparator_32bits (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_lt,
    output logic        o_gt
);
    assign o_lt = i_a < i_b;
    assign o_gt = i_a > i_b;
endmodule

module comparator_frame_minmax #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_min,
    output logic [DATA_W-1:0] o_max,
    output logic [CNT_W-1:0]  o_min_idx,
    output logic [CNT_W-1:0]  o_max_idx,
    output logic [CNT_W-1:0]  o_count
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state, state_nxt;
    logic   in_acc, out_acc;
    logic   lt_min, gt_max;
    logic   unused_cmp_min_gt, unused_cmp_max_lt;

    comparator_32bits u_cmp_min (
        .i_a  (i_data),
        .i_b  (o_min),
        .o_lt (lt_min),
        .o_gt (unused_cmp_min_gt)
    );

    comparator_32bits u_cmp_max (
        .i_a  (i_data),
        .i_b  (o_max),
        .o_lt (unused_cmp_max_lt),
        .o_gt (gt_max)
    );

    assign o_ready = (state != HOLD);
    assign o_valid = (state == HOLD);
    assign in_acc  = i_valid & o_ready;
    assign out_acc = o_valid & i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_acc) state_nxt = i_last ? HOLD : ACCUM;
            ACCUM:   if (in_acc && i_last) state_nxt = HOLD;
            HOLD:    if (out_acc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Ties never update, so each index keeps the first occurrence
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_min     <= '0;
            o_max     <= '0;
            o_min_idx <= '0;
            o_max_idx <= '0;
            o_count   <= '0;
        end else if (in_acc) begin
            if (state == IDLE) begin
                o_min     <= i_data;
                o_max     <= i_data;
                o_min_idx <= '0;
                o_max_idx <= '0;
                o_count   <= CNT_W'(1);
            end else begin
                if (lt_min) begin
                    o_min     <= i_data;
                    o_min_idx <= o_count;
                end
                if (gt_max) begin
                    o_max     <= i_data;
                    o_max_idx <= o_count;
                end
                if (o_count != CNT_MAX) o_count <= o_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_comparator_frame_minmax.sv
// Bench for comparator_frame_minmax: frame-level reference model plus
// directed frames, back-pressure, mid-frame reset and count saturation.
module tb_comparator_frame_minmax;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    typedef struct {
        logic [31:0] mn;
        logic [31:0] mx;
        int          mni;
        int          mxi;
        int          cnt;
    } res_t;

    logic          i_clk = 0;
    logic          i_rst = 1;
    logic          i_valid = 0;
    logic          o_ready;
    logic [31:0]   i_data = '0;
    logic          i_last = 0;
    logic          o_valid;
    logic          i_ready = 1;
    logic [31:0]   o_min, o_max;
    logic [CW-1:0] o_min_idx, o_max_idx, o_count;

    int errors = 0;
    int checks = 0;

    logic [31:0] frame[$];
    res_t        exp_q[$];
    res_t        cur;
    bit          have = 0;
    res_t        pin;

    comparator_frame_minmax #(.DATA_W(32), .CNT_W(CW)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data    (i_data),
        .i_last    (i_last),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_min     (o_min),
        .o_max     (o_max),
        .o_min_idx (o_min_idx),
        .o_max_idx (o_max_idx),
        .o_count   (o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", n, act, req);
        end
    endtask

    // Frame statistics straight from the definition of min/max/first index
    function automatic res_t model();
        res_t r;
        r.mn = frame[0];
        r.mx = frame[0];
        r.mni = 0;
        r.mxi = 0;
        for (int i = 1; i < frame.size(); i++) begin
            if (frame[i] < r.mn) begin
                r.mn = frame[i];
                r.mni = (i > SAT) ? SAT : i;
            end
            if (frame[i] > r.mx) begin
                r.mx = frame[i];
                r.mxi = (i > SAT) ? SAT : i;
            end
        end
        r.cnt = (frame.size() > SAT) ? SAT : frame.size();
        return r;
    endfunction

    always @(negedge i_clk) begin
        if (!i_rst) begin
            chk("ready_vs_valid", 32'(o_ready), 32'(!o_valid));
            if (o_valid) begin
                if (!have) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: actual=valid required=idle");
                    end else begin
                        cur = exp_q.pop_front();
                        have = 1;
                    end
                end
                if (have) begin
                    chk("min", o_min, cur.mn);
                    chk("max", o_max, cur.mx);
                    chk("min_idx", 32'(o_min_idx), 32'(cur.mni));
                    chk("max_idx", 32'(o_max_idx), 32'(cur.mxi));
                    chk("count", 32'(o_count), 32'(cur.cnt));
                end
            end else begin
                have = 0;
            end
        end
    end

    task automatic beat(input logic [31:0] d, input logic l, output int t);
        i_valid = 1;
        i_data = d;
        i_last = l;
        t = 0;
        forever begin
            @(posedge i_clk);
            t++;
            if (o_ready) break;
            if (t >= 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: actual=%0d required=<200", t);
                break;
            end
        end
        #1;
        i_valid = 0;
        i_data = 'x;
        i_last = 0;
    endtask

    task automatic send_frame(input int hold, input bit gaps);
        int t;
        i_ready = (hold == 0);
        foreach (frame[i]) begin
            if (gaps && i > 0) begin
                repeat ($urandom_range(0, 2)) @(posedge i_clk);
                #1;
            end
            beat(frame[i], i == frame.size() - 1, t);
        end
        exp_q.push_back(model());
        @(negedge i_clk);
        chk("latency_valid", 32'(o_valid), 32'd1);
        repeat (hold) @(negedge i_clk);
        i_ready = 1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1;
        i_valid = 0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 0;
        @(negedge i_clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_min", o_min, 32'd0);
        chk("rst_max", o_max, 32'd0);
        chk("rst_idx", 32'({o_min_idx, o_max_idx}), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int t;
        logic [31:0] held_max;

        do_reset();

        frame = '{32'd5};
        pin = model();
        chk("pin1_min", pin.mn, 32'd5);
        chk("pin1_cnt", 32'(pin.cnt), 32'd1);
        send_frame(0, 0);

        frame = '{32'd7, 32'd3, 32'd9, 32'd3, 32'd9, 32'd1};
        pin = model();
        chk("pin2_min", pin.mn, 32'd1);
        chk("pin2_mni", 32'(pin.mni), 32'd5);
        chk("pin2_max", pin.mx, 32'd9);
        chk("pin2_mxi", 32'(pin.mxi), 32'd2);
        chk("pin2_cnt", 32'(pin.cnt), 32'd6);
        send_frame(0, 0);

        frame = '{32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'hFFFFFFFF};
        pin = model();
        chk("pin3_min", pin.mn, 32'd0);
        chk("pin3_mni", 32'(pin.mni), 32'd2);
        chk("pin3_max", pin.mx, 32'hFFFFFFFF);
        chk("pin3_mxi", 32'(pin.mxi), 32'd3);
        send_frame(1, 1);

        // Back-pressure: result held while the next frame's first beat waits
        i_ready = 0;
        frame = '{32'd10, 32'd20};
        beat(32'd10, 0, t);
        beat(32'd20, 1, t);
        exp_q.push_back(model());
        i_valid = 1;
        i_data = 32'd42;
        i_last = 1;
        held_max = 32'd20;
        repeat (5) begin
            @(negedge i_clk);
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_ready", 32'(o_ready), 32'd0);
            chk("hold_max", o_max, held_max);
        end
        i_ready = 1;
        beat(32'd42, 1, t);
        chk("restart_edges", 32'(t), 32'd2);
        frame = '{32'd42};
        exp_q.push_back(model());
        @(posedge i_clk);
        #1;

        // Reset discards a partial frame
        beat(32'd2, 0, t);
        beat(32'd8, 0, t);
        do_reset();
        frame = '{32'd4, 32'd6};
        pin = model();
        chk("pin5_mni", 32'(pin.mni), 32'd0);
        chk("pin5_mxi", 32'(pin.mxi), 32'd1);
        send_frame(0, 0);

        // Saturation: 20 beats, last one a new maximum
        frame = '{};
        frame.push_back(32'd50);
        for (int i = 1; i < 19; i++) frame.push_back(32'd10);
        frame.push_back(32'd1000);
        pin = model();
        chk("pin6_cnt", 32'(pin.cnt), 32'd15);
        chk("pin6_mxi", 32'(pin.mxi), 32'd15);
        chk("pin6_mni", 32'(pin.mni), 32'd1);
        send_frame(2, 0);

        for (int f = 0; f < 300; f++) begin
            int n;
            bit narrow;
            n = $urandom_range(1, 22);
            narrow = $urandom_range(0, 1) == 1;
            frame = '{};
            for (int i = 0; i < n; i++)
                frame.push_back(narrow ? 32'($urandom_range(0, 7)) : $urandom);
            send_frame($urandom_range(0, 3), 1);
        end

        repeat (3) @(negedge i_clk);
        chk("drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
